select_result_fifo: RTL and testbench

//  - Elastic FIFO on the result channel of the dataflow select unit. It sits directly

---
 rtl/select_result_fifo.sv | 132 +++++++++++++
 tb/tb_select_result_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_result_fifo.sv
// -----------------------------------------------------------------------------
// select_result_fifo
//
// Elastic FIFO on the result channel of the dataflow select unit. It holds up to
// NUM_SLOTS tokens in order, so that the select unit's result_ready never depends
// combinationally on the downstream consumer's ready.
//
// Parameters
//   DATA_TYPE  token data width in bits (>=1)
//   NUM_SLOTS  storage depth in tokens (>=2, any value, not only powers of two)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   ins         in   token data from the select result
//   ins_valid   in   upstream token present
//   ins_ready   out  FIFO accepts a token this cycle (only !full, never outs_ready)
//   outs        out  head token data (don't-care while outs_valid=0)
//   outs_valid  out  head token present
//   outs_ready  in   downstream accepts the head token
//   count       out  number of stored tokens
//   state_dbg   out  occupancy state: 0 EMPTY, 1 PARTIAL, 2 FULL
//
// Handshake: a token moves across a side only on a rising clk edge where that
// side's valid and ready are both high. valid never waits for ready, and once
// outs_valid is high it stays high with outs stable until the token is popped.
//
// Optional feature: define SELECT_RESULT_FIFO_BYPASS_EN for transparent mode.
// While the FIFO is empty, ins/ins_valid then drive outs/outs_valid directly;
// a token taken by the consumer in that same cycle is never written.
// Without the macro the FIFO is purely registered (minimum latency one cycle).
// -----------------------------------------------------------------------------
module select_result_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_SLOTS = 4,
  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready,
  output logic [CNT_W-1:0]     count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  fifo_state_e          state;

  logic empty, full, push, pop, bypass, wr_en;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(NUM_SLOTS));

  // Gated by rst so both sides look idle while reset is held.
  assign ins_ready = rst & ~full;
  assign push      = ins_valid & ins_ready;

`ifdef SELECT_RESULT_FIFO_BYPASS_EN
  assign outs_valid = rst & (~empty | ins_valid);
  assign outs       = empty ? ins : mem_q[rd_ptr_q];
  // Empty and consumer ready: the token flows straight through, never stored.
  assign bypass     = empty & push & outs_ready;
`else
  assign outs_valid = rst & ~empty;
  assign outs       = mem_q[rd_ptr_q];
  assign bypass     = 1'b0;
`endif

  // A pop only ever removes a stored token; a bypassed token is not a pop.
  assign pop   = outs_valid & outs_ready & ~empty;
  assign wr_en = push & ~bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; outs is ignored while outs_valid=0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ins;
  end

  // Occupancy state is implied by count.
  always_comb begin
    state = ST_PARTIAL;
    if (empty)     state = ST_EMPTY;
    else if (full) state = ST_FULL;
  end

  assign count     = count_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_select_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_select_result_fifo
//
// Two instances: dut4 (NUM_SLOTS=4) and dut3 (NUM_SLOTS=3, wrap test).
// A queue per instance models the stored tokens; expected handshake outputs are
// derived from queue occupancy each cycle.
// -----------------------------------------------------------------------------
module tb_select_result_fifo;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut4 ----------------
  logic [W-1:0] ins4 = '0;
  logic         ins_valid4 = 1'b0;
  logic         ins_ready4;
  logic [W-1:0] outs4;
  logic         outs_valid4;
  logic         outs_ready4 = 1'b0;
  logic [2:0]   count4;
  logic [1:0]   state4;

  select_result_fifo #(.DATA_TYPE(W), .NUM_SLOTS(4)) dut4 (
    .clk(clk), .rst(rst),
    .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4),
    .count(count4), .state_dbg(state4)
  );

  // ---------------- dut3 ----------------
  logic [W-1:0] ins3 = '0;
  logic         ins_valid3 = 1'b0;
  logic         ins_ready3;
  logic [W-1:0] outs3;
  logic         outs_valid3;
  logic         outs_ready3 = 1'b0;
  logic [1:0]   count3;
  logic [1:0]   state3;

  select_result_fifo #(.DATA_TYPE(W), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3),
    .count(count3), .state_dbg(state3)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] q4[$];
  logic [W-1:0] q3[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic         d_dlv;
  logic [W-1:0] d_val;

  // One clock cycle on the selected instance (0: dut4, 1: dut3).
  // Called just after a rising edge; inputs are applied, outputs are checked at
  // the falling edge, and the model is updated from the expected handshake.
  task automatic step(input int sel, input logic vin, input logic [W-1:0] din,
                      input logic ordy, output logic dlv, output logic [W-1:0] dval);
    int depth, sz, o_cnt;
    logic exp_rdy, exp_vld, byp;
    logic [W-1:0] exp_out, o_out;
    logic o_rdy, o_vld;
    logic [1:0] exp_st, o_st;
    depth = (sel == 0) ? 4 : 3;
    sz    = (sel == 0) ? q4.size() : q3.size();
    if (sel == 0) begin
      ins4 = din; ins_valid4 = vin; outs_ready4 = ordy;
      ins_valid3 = 1'b0; outs_ready3 = 1'b0;
    end else begin
      ins3 = din; ins_valid3 = vin; outs_ready3 = ordy;
      ins_valid4 = 1'b0; outs_ready4 = 1'b0;
    end
    exp_rdy = (sz < depth);
    exp_vld = (sz != 0);
    exp_out = (sz == 0) ? din : ((sel == 0) ? q4[0] : q3[0]);
    byp     = 1'b0;
`ifdef SELECT_RESULT_FIFO_BYPASS_EN
    if (sz == 0) begin
      exp_vld = vin;
      byp     = vin && ordy;
    end
`endif
    exp_st = (sz == 0) ? 2'd0 : ((sz == depth) ? 2'd2 : 2'd1);
    @(negedge clk);
    if (sel == 0) begin
      o_rdy = ins_ready4; o_vld = outs_valid4; o_out = outs4; o_cnt = int'(count4); o_st = state4;
    end else begin
      o_rdy = ins_ready3; o_vld = outs_valid3; o_out = outs3; o_cnt = int'(count3); o_st = state3;
    end
    checks++;
    if (o_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL ins_ready dut%0d t=%0t got %b expected %b", sel, $time, o_rdy, exp_rdy);
    end
    checks++;
    if (o_vld !== exp_vld) begin
      errors++;
      $display("FAIL outs_valid dut%0d t=%0t got %b expected %b", sel, $time, o_vld, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (o_out !== exp_out) begin
        errors++;
        $display("FAIL outs dut%0d t=%0t got %0h expected %0h", sel, $time, o_out, exp_out);
      end
    end
    checks++;
    if (o_cnt != sz) begin
      errors++;
      $display("FAIL count dut%0d t=%0t got %0d expected %0d", sel, $time, o_cnt, sz);
    end
    checks++;
    if (o_st !== exp_st) begin
      errors++;
      $display("FAIL state_dbg dut%0d t=%0t got %0d expected %0d", sel, $time, o_st, exp_st);
    end
    dlv  = exp_vld && ordy;
    dval = o_out;
    @(posedge clk);
    if (sz != 0 && ordy) begin
      if (sel == 0) void'(q4.pop_front()); else void'(q3.pop_front());
    end
    if (vin && exp_rdy && !byp) begin
      if (sel == 0) q4.push_back(din); else q3.push_back(din);
    end
    #1;
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 10; i++) begin
      if (((sel == 0) ? q4.size() : q3.size()) == 0) break;
      step(sel, 1'b0, '0, 1'b1, d_dlv, d_val);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    ins4 = 32'hA5; ins_valid4 = 1'b1; outs_ready4 = 1'b1;
    ins3 = 32'hA5; ins_valid3 = 1'b1; outs_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ins_ready4 !== 1'b0 || ins_ready3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ins_ready got %b/%b expected 0/0", ins_ready4, ins_ready3);
    end
    checks++;
    if (outs_valid4 !== 1'b0 || outs_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs_valid got %b/%b expected 0/0", outs_valid4, outs_valid3);
    end
    checks++;
    if (count4 !== 3'd0 || count3 !== 2'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d expected 0/0", count4, count3);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    q4.delete(); q3.delete();
    step(0, 1'b1, 32'hA5, 1'b0, d_dlv, d_val);
    step(0, 1'b0, '0, 1'b0, d_dlv, d_val);   // expects outs=A5, count=1
    drain(0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) step(0, 1'b1, W'(i), 1'b0, d_dlv, d_val);
    for (int i = 0; i < 5; i++) step(0, 1'b0, '0, 1'b1, d_dlv, d_val);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step(0, 1'b1, 32'h20 + W'(i), 1'b0, d_dlv, d_val);
    step(0, 1'b1, 32'h55, 1'b1, d_dlv, d_val);  // full: pop only
    step(0, 1'b1, 32'h56, 1'b1, d_dlv, d_val);  // count 3: push and pop
    step(0, 1'b0, '0, 1'b0, d_dlv, d_val);      // count still 3
    drain(0);
  endtask

  task automatic test_wrap();
    int sent = 0, recv = 0;
    logic ordy = 1'b1;
    logic vin;
    exp_q.delete();
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      vin = (sent < 10);
      step(1, vin, 32'h10 + W'(sent), ordy, d_dlv, d_val);
      if (vin && q3.size() != 0 && q3[$] == 32'h10 + W'(sent)) begin
        exp_q.push_back(32'h10 + W'(sent));
        sent++;
      end else if (vin && d_dlv && d_val == 32'h10 + W'(sent) && exp_q.size() == 0) begin
        exp_q.push_back(32'h10 + W'(sent));   // passed straight through
        sent++;
      end
      if (d_dlv) begin
        checks++;
        if (exp_q.size() == 0 || d_val !== exp_q[0]) begin
          errors++;
          $display("FAIL wrap_order got %0h expected %0h", d_val, 32'h10 + W'(recv));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        recv++;
      end
      ordy = ~ordy;
    end
    checks++;
    if (recv != 10) begin
      errors++;
      $display("FAIL wrap_complete got %0d tokens expected 10", recv);
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    step(0, 1'b1, 32'h7, 1'b0, d_dlv, d_val);
    step(0, 1'b1, 32'h8, 1'b0, d_dlv, d_val);
    ins_valid4 = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs_valid4 !== 1'b0 || count4 !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b count=%0d expected valid=0 count=0", outs_valid4, count4);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    q4.delete(); q3.delete();
    step(0, 1'b1, 32'h9, 1'b0, d_dlv, d_val);
    step(0, 1'b0, '0, 1'b0, d_dlv, d_val);   // head must be 0x9
    drain(0);
  endtask

  task automatic test_bypass();
    step(0, 1'b1, 32'hBEEF, 1'b1, d_dlv, d_val);
    step(0, 1'b0, '0, 1'b0, d_dlv, d_val);
    drain(0);
  endtask

  task automatic test_random(input int sel, input int cycles, input int ready_pct);
    for (int i = 0; i < cycles; i++) begin
      step(sel, 1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 99) < ready_pct), d_dlv, d_val);
    end
    drain(sel);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    test_bypass();
    test_random(0, 300, 30);
    test_random(0, 300, 80);
    test_random(1, 300, 50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
